// File: rtl/wb_lcd_writer_pkg.sv
// wb_lcd_writer shared definitions: register map, FSM states, STATUS layout.
// The optional fill engine is enabled with WB_LCD_FILL_EN.
package wb_lcd_pkg;

    localparam int ENTRY_W = 9;

    localparam logic [2:0] REG_CMD     = 3'd0;
    localparam logic [2:0] REG_DATA    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_CTRL    = 3'd3;
    localparam logic [2:0] REG_FILL_LO = 3'd4;
    localparam logic [2:0] REG_FILL_HI = 3'd5;
    localparam logic [2:0] REG_FILL_GO = 3'd6;

    localparam int STAT_FULL = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_LVL  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } lcd_state_e;

    function automatic logic [4:0] sat_level(input int unsigned lvl);
        if (lvl > 31) return 5'd31;
        return 5'(lvl);
    endfunction

endpackage

// File: rtl/wb_lcd_writer_if.sv
// Wishbone slave port of wb_lcd_writer (8-bit data, single-cycle strobe).
// Shared by both the fill-enabled and default builds.
interface wb_lcd_writer_if;
    logic       stb_i;
    logic       we_i;
    logic [2:0] adr_i;
    logic [7:0] dat_i;
    logic       ack_o;
    logic [7:0] dat_o;

    modport master (
        output stb_i, we_i, adr_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  stb_i, we_i, adr_i, dat_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/wb_lcd_writer_fifo.sv
// Synchronous FIFO for queued LCD bytes; pointers carry an extra wrap bit.
// Used by wb_lcd_writer in every build (WB_LCD_FILL_EN has no effect here).
module lcd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    always_comb begin
        level_o = wptr_q - rptr_q;
        full_o  = (level_o == (AW + 1)'(DEPTH));
        empty_o = (wptr_q == rptr_q);
        rdata_o = mem_q[rptr_q[AW-1:0]];
        // A push into a full FIFO is legal only alongside a pop.
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/wb_lcd_writer.sv
// Wishbone register front-end feeding a FIFO and an 8080-style LCD write FSM.
// Define WB_LCD_FILL_EN to build the repeated-byte fill engine (regs 4-6).
module wb_lcd_writer
    import wb_lcd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_lcd_writer_if.slave  wb,
    output logic            busy_o,
    output logic            lcd_nreset,
    output logic            lcd_cmd_data,
    output logic            lcd_write_edge,
    output logic [7:0]      lcd_dout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 16;
    localparam logic [CW-1:0] SETUP_END  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_END = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_CYCLES - 1);

    logic               push, pop, full, empty;
    logic [AW:0]        level;
    logic [ENTRY_W-1:0] wdata, rdata;
    lcd_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         dout_q, dout_d;
    logic               cd_q, cd_d;
    logic               ack_q, ack_d;
    logic [7:0]         dat_q, dat_d;
    logic [7:0]         ctrl_q, ctrl_d;
    logic [7:0]         rd_val, status;
    logic               idle, req, is_push, accept, fill_act;

`ifdef WB_LCD_FILL_EN
    logic [15:0] fill_n_q, fill_n_d;
    logic [15:0] fill_rem_q, fill_rem_d;
    logic [7:0]  fill_byte_q, fill_byte_d;
    logic        is_go, fill_take;
    assign fill_act = (fill_rem_q != 16'd0);
`else
    assign fill_act = 1'b0;
`endif

    lcd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    // Bus decode: FIFO writes stall only when full with no pop this cycle.
    always_comb begin
        req     = wb.stb_i && !ack_q;
        is_push = wb.we_i && (wb.adr_i == REG_CMD || wb.adr_i == REG_DATA);
`ifdef WB_LCD_FILL_EN
        is_go   = wb.we_i && (wb.adr_i == REG_FILL_GO);
        accept  = req && (is_push ? (!full || pop)
                        : (is_go ? (empty && idle && !fill_act) : 1'b1));
`else
        accept  = req && (!is_push || !full || pop);
`endif
        push    = accept && is_push;
        wdata   = {wb.adr_i == REG_DATA, wb.dat_i};
        status  = {sat_level(32'(level)), 1'b0, busy_o, full};
        rd_val  = 8'h00;
        unique case (wb.adr_i)
            REG_STATUS: rd_val = status;
            REG_CTRL:   rd_val = ctrl_q;
            default:    rd_val = 8'h00;
        endcase
        ack_d  = accept;
        dat_d  = (accept && !wb.we_i) ? rd_val : 8'h00;
        ctrl_d = ctrl_q;
        if (accept && wb.we_i && wb.adr_i == REG_CTRL) ctrl_d = wb.dat_i;
    end

`ifdef WB_LCD_FILL_EN
    always_comb begin
        fill_n_d    = fill_n_q;
        fill_rem_d  = fill_rem_q;
        fill_byte_d = fill_byte_q;
        if (accept && wb.we_i && wb.adr_i == REG_FILL_LO) fill_n_d[7:0]  = wb.dat_i;
        if (accept && wb.we_i && wb.adr_i == REG_FILL_HI) fill_n_d[15:8] = wb.dat_i;
        if (accept && is_go) begin
            fill_rem_d  = fill_n_q;
            fill_byte_d = wb.dat_i;
        end else if (fill_take) begin
            fill_rem_d  = fill_rem_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fill_n_q    <= '0;
            fill_rem_q  <= '0;
            fill_byte_q <= '0;
        end else begin
            fill_n_q    <= fill_n_d;
            fill_rem_q  <= fill_rem_d;
            fill_byte_q <= fill_byte_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus data loads only on the IDLE pop, so it is stable for the whole cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        dout_d  = dout_q;
        cd_d    = cd_q;
`ifdef WB_LCD_FILL_EN
        fill_take = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
`ifdef WB_LCD_FILL_EN
                if (fill_act) begin
                    fill_take = 1'b1;
                    dout_d    = fill_byte_q;
                    cd_d      = 1'b1;
                    state_d   = ST_SETUP;
                end else
`endif
                if (!empty) begin
                    pop            = 1'b1;
                    {cd_d, dout_d} = rdata;
                    state_d        = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETUP_END) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == STROBE_END) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HOLD_END) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        idle           = (state_q == ST_IDLE);
        lcd_write_edge = (state_q != ST_STROBE);
        busy_o         = !empty || !idle || fill_act;
        lcd_dout       = dout_q;
        lcd_cmd_data   = cd_q;
        lcd_nreset     = ctrl_q[0];
        wb.ack_o       = ack_q;
        wb.dat_o       = dat_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dout_q <= 8'h00;
            cd_q   <= 1'b1;
            ack_q  <= 1'b0;
            dat_q  <= 8'h00;
            ctrl_q <= 8'h00;
        end else begin
            dout_q <= dout_d;
            cd_q   <= cd_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            ctrl_q <= ctrl_d;
        end
    end

endmodule
